// File: rtl/seq1011_pkg.sv
// Shared 1011 detector encoding and next-state/output functions.
// The same functions serve the single-channel detector and the time-multiplexed scheduler.
package seq1011_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,  // idle
        S1 = 2'b01,  // seen "1"
        S2 = 2'b10,  // seen "10"
        S3 = 2'b11   // seen "101"
    } state_t;

    // Overlapping 1011 detector next state for input bit x.
    function automatic state_t next_state(input state_t s, input logic x);
        state_t n;
        case (s)
            S0:      n = x ? S1 : S0;
            S1:      n = x ? S1 : S2;
            S2:      n = x ? S3 : S0;
            S3:      n = x ? S1 : S2;
            default: n = S0;
        endcase
        return n;
    endfunction

    // Mealy match: the bit that completes "1011".
    function automatic logic match(input state_t s, input logic x);
        return (s == S3) && x;
    endfunction

endpackage

// File: rtl/seq1011_rr_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after the pointer.
// The pointer advances past the winner only when the owner pulses upd.
module rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N-1:0]     req,
    input  logic             upd,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Rotating priority search starting at ptr_q, wrapping modulo N.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] idx_v;
        logic             found;
        // NOTE: every variable gets a default before any conditional write; otherwise a latch is inferred.
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        idx_v   = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N) idx = idx - N;
            idx_v = IDX_W'(idx);
            if (!found && req[idx_v]) begin
                found        = 1'b1;
                gnt[idx_v]   = 1'b1;
                gnt_idx      = idx_v;
            end
        end
    end

    // Next pointer: one past the winner, wrapping at N-1; held when nothing is granted.
    always_comb begin
        ptr_d = ptr_q;
        if (upd) ptr_d = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end

    // Pointer register.
    always_ff @(posedge clk or posedge clr) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values, independent of statement order.
        if (clr) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/seq1011_rr_sched.sv
// Time-multiplexed 1011 detector: N_CH serial channels share one detector datapath.
// Each cycle at most one pending bit is granted round-robin and pushed through the detector;
// the result appears registered one cycle later tagged with its channel.
module seq1011_rr_sched
    import seq1011_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [N_CH-1:0]          bit_in,
    input  logic [N_CH-1:0]          bit_vld,
    output logic [N_CH-1:0]          bit_rdy,
    input  logic [N_CH-1:0]          chan_clr,
    output logic                     z_vld,
    output logic [$clog2(N_CH)-1:0]  z_ch,
    output logic                     z,
    output logic [N_CH*CNT_W-1:0]    match_cnt
);

    localparam int               IDX_W   = $clog2(N_CH);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N_CH-1:0]  eligible;
    logic [N_CH-1:0]  gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             any_gnt;

    state_t           state_q [N_CH];
    state_t           state_d [N_CH];
    logic [CNT_W-1:0] cnt_q   [N_CH];
    logic [CNT_W-1:0] cnt_d   [N_CH];

    logic             z_vld_q, z_vld_d;
    logic [IDX_W-1:0] z_ch_q,  z_ch_d;
    logic             z_q,     z_d;

    // A channel being soft-cleared is masked from arbitration so its pending bit waits;
    // nothing is granted while clr is high.
    assign eligible = bit_vld & ~chan_clr & {N_CH{~clr}};
    assign any_gnt  = |gnt;
    assign bit_rdy  = gnt;

    rr_arbiter #(.N(N_CH)) u_arb (
        .clk     (clk),
        .clr     (clr),
        .req     (eligible),
        .upd     (any_gnt),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Next state: granted channel steps the shared detector, cleared channels restart, others hold.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (chan_clr[i]) begin
                state_d[i] = S0;
                cnt_d[i]   = '0;
            end else if (gnt[i]) begin
                state_d[i] = next_state(state_q[i], bit_in[i]);
                if (match(state_q[i], bit_in[i]) && (cnt_q[i] != CNT_MAX))
                    cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
        z_vld_d = any_gnt;
        z_ch_d  = z_ch_q;
        z_d     = z_q;
        if (any_gnt) begin
            z_ch_d = gnt_idx;
            z_d    = match(state_q[gnt_idx], bit_in[gnt_idx]);
        end
    end

    // State, counter and result registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            // NOTE: the per-channel arrays are small flop arrays, not RAM, so they take the async reset.
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= S0;
                cnt_q[i]   <= '0;
            end
            z_vld_q <= 1'b0;
            z_ch_q  <= '0;
            z_q     <= 1'b0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            z_vld_q <= z_vld_d;
            z_ch_q  <= z_ch_d;
            z_q     <= z_d;
        end
    end

    // Outputs: registered result and packed counter view.
    always_comb begin
        z_vld = z_vld_q;
        z_ch  = z_ch_q;
        z     = z_q;
        for (int i = 0; i < N_CH; i++) match_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end

endmodule

// File: tb/tb_seq1011_rr_sched.sv
// Directed bench for seq1011_rr_sched: table-driven vectors plus hand-written
// sequences for saturation, soft clear and asynchronous reset.
module tb_seq1011_rr_sched;

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] bit_in, bit_vld, chan_clr;

    logic [3:0]  bit_rdy,  bit_rdy2;
    logic        z_vld,    z_vld2;
    logic [1:0]  z_ch,     z_ch2;
    logic        z,        z2;
    logic [31:0] mc;
    logic [7:0]  mc2;

    int n_tests = 0;
    int n_fail  = 0;

    seq1011_rr_sched #(.N_CH(4), .CNT_W(8)) dut (
        .clk(clk), .clr(clr), .bit_in(bit_in), .bit_vld(bit_vld), .bit_rdy(bit_rdy),
        .chan_clr(chan_clr), .z_vld(z_vld), .z_ch(z_ch), .z(z), .match_cnt(mc)
    );

    seq1011_rr_sched #(.N_CH(4), .CNT_W(2)) dut_sat (
        .clk(clk), .clr(clr), .bit_in(bit_in), .bit_vld(bit_vld), .bit_rdy(bit_rdy2),
        .chan_clr(chan_clr), .z_vld(z_vld2), .z_ch(z_ch2), .z(z2), .match_cnt(mc2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] bin;
        logic [3:0] cclr;
        logic [3:0] rdy;   // expected grant before the edge
        logic       zvld;  // expected registered result after the edge
        logic [1:0] zch;
        logic       z;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] vld, input logic [3:0] bin, input logic [3:0] cclr,
                                input logic [3:0] rdy, input logic zvld, input logic [1:0] zch,
                                input logic zz);
        vec_t v;
        v.vld = vld; v.bin = bin; v.cclr = cclr; v.rdy = rdy;
        v.zvld = zvld; v.zch = zch; v.z = zz;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one vector shortly after a rising edge, check the grant, then the result after the next edge.
    task automatic run_vec(input vec_t v, input string tag, input int i);
        bit_vld = v.vld; bit_in = v.bin; chan_clr = v.cclr;
        #1;
        check($sformatf("%s[%0d] bit_rdy", tag, i), 32'(bit_rdy), 32'(v.rdy));
        @(posedge clk); #1;
        check($sformatf("%s[%0d] z_vld", tag, i), 32'(z_vld), 32'(v.zvld));
        check($sformatf("%s[%0d] z_ch",  tag, i), 32'(z_ch),  32'(v.zch));
        check($sformatf("%s[%0d] z",     tag, i), 32'(z),     32'(v.z));
    endtask

    // Synchronous-looking reset window with checks of the reset state while clr is held.
    task automatic do_reset(input string tag);
        clr = 1'b1; bit_vld = 4'hF; bit_in = 4'hF; chan_clr = 4'h0;
        @(posedge clk); #1;
        check({tag, " rst bit_rdy"}, 32'(bit_rdy), 32'h0);
        check({tag, " rst z_vld"},   32'(z_vld),   32'h0);
        check({tag, " rst z_ch"},    32'(z_ch),    32'h0);
        check({tag, " rst z"},       32'(z),       32'h0);
        check({tag, " rst cnt"},     mc,           32'h0);
        check({tag, " rst cnt_sat"}, 32'(mc2),     32'h0);
        clr = 1'b0; bit_vld = 4'h0; bit_in = 4'h0;
    endtask

    vec_t t_single [7];
    vec_t t_fair   [5];
    vec_t t_inter  [8];
    vec_t t_clr    [9];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [12:0] s;
        logic        exp_z;

        // Channel 0 alone: 1,0,1,1,0,1,1 -> matches on the 4th and 7th bits.
        t_single[0] = mk(4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 2'd0, 1'b0);
        t_single[1] = mk(4'h1, 4'h0, 4'h0, 4'h1, 1'b1, 2'd0, 1'b0);
        t_single[2] = mk(4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 2'd0, 1'b0);
        t_single[3] = mk(4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 2'd0, 1'b1);
        t_single[4] = mk(4'h1, 4'h0, 4'h0, 4'h1, 1'b1, 2'd0, 1'b0);
        t_single[5] = mk(4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 2'd0, 1'b0);
        t_single[6] = mk(4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 2'd0, 1'b1);

        // All channels valid: grants rotate 0,1,2,3,0.
        t_fair[0] = mk(4'hF, 4'h0, 4'h0, 4'h1, 1'b1, 2'd0, 1'b0);
        t_fair[1] = mk(4'hF, 4'h0, 4'h0, 4'h2, 1'b1, 2'd1, 1'b0);
        t_fair[2] = mk(4'hF, 4'h0, 4'h0, 4'h4, 1'b1, 2'd2, 1'b0);
        t_fair[3] = mk(4'hF, 4'h0, 4'h0, 4'h8, 1'b1, 2'd3, 1'b0);
        t_fair[4] = mk(4'hF, 4'h0, 4'h0, 4'h1, 1'b1, 2'd0, 1'b0);

        // ch1 = 1,0,1,1 and ch2 = 1,1,1,1 interleaved; each source holds its bit until granted.
        t_inter[0] = mk(4'h6, 4'h6, 4'h0, 4'h2, 1'b1, 2'd1, 1'b0);
        t_inter[1] = mk(4'h6, 4'h4, 4'h0, 4'h4, 1'b1, 2'd2, 1'b0);
        t_inter[2] = mk(4'h6, 4'h4, 4'h0, 4'h2, 1'b1, 2'd1, 1'b0);
        t_inter[3] = mk(4'h6, 4'h6, 4'h0, 4'h4, 1'b1, 2'd2, 1'b0);
        t_inter[4] = mk(4'h6, 4'h6, 4'h0, 4'h2, 1'b1, 2'd1, 1'b0);
        t_inter[5] = mk(4'h6, 4'h6, 4'h0, 4'h4, 1'b1, 2'd2, 1'b0);
        t_inter[6] = mk(4'h6, 4'h6, 4'h0, 4'h2, 1'b1, 2'd1, 1'b1);
        t_inter[7] = mk(4'h4, 4'h4, 4'h0, 4'h4, 1'b1, 2'd2, 1'b0);

        // ch3: 1,0,1,1 (match), idle (result held), 0,1 (now S3), soft clear with ch0
        // competing, then the held 1 is granted from S0 and does not match.
        t_clr[0] = mk(4'h8, 4'h8, 4'h0, 4'h8, 1'b1, 2'd3, 1'b0);
        t_clr[1] = mk(4'h8, 4'h0, 4'h0, 4'h8, 1'b1, 2'd3, 1'b0);
        t_clr[2] = mk(4'h8, 4'h8, 4'h0, 4'h8, 1'b1, 2'd3, 1'b0);
        t_clr[3] = mk(4'h8, 4'h8, 4'h0, 4'h8, 1'b1, 2'd3, 1'b1);
        t_clr[4] = mk(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 2'd3, 1'b1);
        t_clr[5] = mk(4'h8, 4'h0, 4'h0, 4'h8, 1'b1, 2'd3, 1'b0);
        t_clr[6] = mk(4'h8, 4'h8, 4'h0, 4'h8, 1'b1, 2'd3, 1'b0);
        t_clr[7] = mk(4'h9, 4'h8, 4'h8, 4'h1, 1'b1, 2'd0, 1'b0);
        t_clr[8] = mk(4'h8, 4'h8, 4'h0, 4'h8, 1'b1, 2'd3, 1'b0);

        // ---------------- single channel stream
        do_reset("single");
        for (int i = 0; i < 7; i++) run_vec(t_single[i], "single", i);
        check("single cnt0", 32'(mc[7:0]), 32'd2);

        // ---------------- fairness
        do_reset("fair");
        for (int i = 0; i < 5; i++) run_vec(t_fair[i], "fair", i);

        // ---------------- interleaving
        do_reset("inter");
        for (int i = 0; i < 8; i++) run_vec(t_inter[i], "inter", i);
        check("inter cnt1", 32'(mc[15:8]),  32'd1);
        check("inter cnt2", 32'(mc[23:16]), 32'd0);

        // ---------------- counter saturation (CNT_W = 2 instance alongside CNT_W = 8)
        do_reset("sat");
        s = 13'b1011011011011;
        for (int k = 0; k < 13; k++) begin
            bit_vld = 4'h1; bit_in = {3'b000, s[12-k]}; chan_clr = 4'h0;
            exp_z = (k == 3) || (k == 6) || (k == 9) || (k == 12);
            #1;
            check($sformatf("sat[%0d] bit_rdy", k), 32'(bit_rdy2), 32'h1);
            @(posedge clk); #1;
            check($sformatf("sat[%0d] z",     k), 32'(z),  32'(exp_z));
            check($sformatf("sat[%0d] z_sat", k), 32'(z2), 32'(exp_z));
            if (k == 9) begin
                check("sat cnt_sat after 3", 32'(mc2[1:0]), 32'd3);
                check("sat cnt after 3",     32'(mc[7:0]),  32'd3);
            end
        end
        check("sat cnt_sat after 4", 32'(mc2[1:0]), 32'd3);
        check("sat cnt after 4",     32'(mc[7:0]),  32'd4);

        // ---------------- per-channel soft clear
        do_reset("cclr");
        for (int i = 0; i < 7; i++) begin
            run_vec(t_clr[i], "cclr", i);
            if (i == 6) check("cclr cnt3 before", 32'(mc[31:24]), 32'd1);
        end
        run_vec(t_clr[7], "cclr", 7);
        check("cclr cnt3 cleared", 32'(mc[31:24]), 32'd0);
        run_vec(t_clr[8], "cclr", 8);
        check("cclr cnt3 after", 32'(mc[31:24]), 32'd0);

        // ---------------- asynchronous clr mid-operation
        do_reset("aclr");
        for (int i = 0; i < 6; i++)
            run_vec(mk(4'h1, (i == 1 || i == 4) ? 4'h0 : 4'h1, 4'h0, 4'h1, 1'b1, 2'd0, (i == 3)),
                    "aclr", i);
        check("aclr cnt0 before", 32'(mc[7:0]), 32'd1);
        bit_vld = 4'h1; bit_in = 4'h1; chan_clr = 4'h0;  // would complete 1011 on ch0
        #2;
        clr = 1'b1;
        #1;
        check("aclr async bit_rdy", 32'(bit_rdy), 32'h0);
        check("aclr async z_vld",   32'(z_vld),   32'h0);
        check("aclr async z",       32'(z),       32'h0);
        check("aclr async cnt",     mc,           32'h0);
        @(posedge clk); #1;
        check("aclr no inflight z_vld", 32'(z_vld), 32'h0);
        clr = 1'b0;
        run_vec(mk(4'h1, 4'h1, 4'h0, 4'h1, 1'b1, 2'd0, 1'b0), "aclr post", 0);
        check("aclr post cnt",     mc,        32'h0);
        check("aclr post cnt_sat", 32'(mc2),  32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq1011_rr_sched.md
Name: seq1011_rr_sched

Overview:
- Time-multiplexed scheduler that shares one 1011 sequence-detector next-state/output datapath across N_CH serial bit channels.
- Holds a 2-bit detector state and a saturating match counter per channel.
- Each cycle, a round-robin arbiter grants at most one channel with a pending bit, and that bit is pushed through the shared detector logic.
- Sits between the serial front-end channels and the event/statistics logic.

Parameters:
- N_CH, 4, number of requesting channels (2..16).
- CNT_W, 8, width of each per-channel saturating match counter.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- bit_in  in  N_CH  serial data bit per channel.
- bit_vld  in  N_CH  channel has a bit pending.
- bit_rdy  out  N_CH  one-hot grant; bit consumed when bit_vld[i] & bit_rdy[i].
- chan_clr  in  N_CH  synchronous per-channel soft clear.
- z_vld  out  1  registered result valid.
- z_ch  out  $clog2(N_CH)  channel index of the result.
- z  out  1  1 = that bit completed 1011 (overlapping).
- match_cnt  out  N_CH*CNT_W  packed per-channel match counters; channel i at [i*CNT_W +: CNT_W].

Behaviour:
- Reset (clr=1), asynchronous:
  - all channel states = S0; all match_cnt = 0.
  - rr pointer = 0.
  - z_vld = 0, z_ch = 0, z = 0.
  - bit_rdy = 0 while clr is high.
- Detector states per channel (2-bit encoding):
  - S0 = 00: idle.
  - S1 = 01: seen "1".
  - S2 = 10: seen "10".
  - S3 = 11: seen "101".
- Detector transitions (x = granted bit):
  - S0: x=0 -> S0; x=1 -> S1.
  - S1: x=0 -> S2; x=1 -> S1.
  - S2: x=0 -> S0; x=1 -> S3.
  - S3: x=0 -> S2; x=1 -> S1, match.
  - Match (Mealy) = (state == S3) & (x == 1).
- Arbitration, combinational in cycle T:
  - Eligible[i] = bit_vld[i] & ~chan_clr[i].
  - Grant goes to the first eligible channel searching ptr, ptr+1, ... mod N_CH.
  - bit_rdy is one-hot or zero; bit_rdy[i] may only be 1 when bit_vld[i] is 1.
- Pointer update:
  - On a grant to g: ptr <= (g+1) mod N_CH.
  - No grant: ptr unchanged.
- Datapath on grant to g at edge ending cycle T:
  - state[g] <= next state.
  - If match: match_cnt[g] <= match_cnt[g] + 1, saturating at 2^CNT_W - 1 (no wrap).
  - Ungranted channels hold state and counter.
- Output timing: results are registered, latency 1.
  - At cycle T+1: z_vld = 1, z_ch = g, z = match.
  - No grant in T: z_vld = 0 at T+1; z_ch/z hold their previous values.
- chan_clr[i] in cycle T:
  - state[i] <= S0 and match_cnt[i] <= 0 at the end of T.
  - Channel i is not eligible in T, so a pending bit is not consumed; the source must hold it.
  - Other channels arbitrate normally.
- Fairness: with all channels continuously valid, each channel is granted exactly once every N_CH cycles.
- A channel whose bit_vld deasserts mid-sequence keeps its state indefinitely; interleaving never corrupts per-channel history.
- clr asserted mid-operation: everything returns to reset values immediately. No result for an in-flight grant is emitted.

Decomposition:
- Package seq1011_pkg:
  - state typedef and the S0..S3 encodings.
  - Function next_state(state, x) and function match(state, x), shared with the single-channel detector.
- Sub-module rr_arbiter:
  - Parameter N, inputs req[N], output one-hot gnt[N] and gnt_idx.
  - Internal pointer, with an update strobe driven by the scheduler.
- Top instantiates rr_arbiter and holds the state/counter register arrays plus the output register.

Test Plan:
- Single channel 0 streams 1,0,1,1,0,1,1 -> z_vld pulses with z = 0,0,0,1,0,0,1; match_cnt[0] = 2.
- All 4 channels bit_vld = 1 continuously -> bit_rdy cycles 0001, 0010, 0100, 1000, 0001; z_ch = 0,1,2,3,0 one cycle later.
- Interleave ch1 = 1,0,1,1 with ch2 = 1,1,1,1 while ch0/ch3 are idle -> exactly one z = 1, on z_ch = 1; match_cnt[2] = 0.
- CNT_W = 2, ch0 fed 1011011011011 -> match_cnt[0] saturates at 3 after the 4th match and stays 3.
- ch3 has a bit pending with chan_clr[3] = 1 -> bit_rdy[3] = 0 that cycle; the next cycle the bit is granted starting from S0.
- Assert clr after ch0 has received 1,0,1, then release and send 1 -> z = 0 (state was reset to S0); all counters read 0.
